rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Sequencer and arbiter for the register-file write port in the multicycle design. After reset it sweeps every register to zero. It then shares the single RF write port between two requesters: A (core writeback) and B (host/debug loader). Arbitration is round-robin over valid/ready handshakes, and the block drives registered RFWE/RFWA/RFWD straight into the register file.

## Interface
Parameters:
- AWL, 5, RF address width; the register count is 2^AWL
- DWL, 32, RF data width
- CLEAR_ON_RESET, 1, when 1 run the zeroing sweep after reset; when 0 go straight to RUN
- ZERO_R0, 1, when 1 accept writes to address 0 but never drive them to the RF

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, synchronous, active-high
- AVALID  in  1  requester A has a write pending
- AREADY  out  1  requester A write accepted this cycle (when AVALID is high)
- AWA  in  AWL  requester A address
- AWD  in  DWL  requester A data
- BVALID  in  1  requester B has a write pending
- BREADY  out  1  requester B write accepted this cycle (when BVALID is high)
- BWA  in  AWL  requester B address
- BWD  in  DWL  requester B data
- RFWE  out  1  RF write enable, registered
- RFWA  out  AWL  RF write address, registered
- RFWD  out  DWL  RF write data, registered
- BUSY  out  1  high while not in RUN

## Operation
- States: RESET, CLEAR, RUN.
  - RST=1 forces RESET from any state, including mid-sweep.
  - RESET→CLEAR on the first edge with RST=0 if CLEAR_ON_RESET=1, otherwise RESET→RUN.
  - CLEAR→RUN after the last sweep address has been issued.
  - RUN holds until RST.
- Reset values: RFWE=0, RFWA=0, RFWD=0, BUSY=1, AREADY=0, BREADY=0, sweep counter=0, round-robin pointer LAST=B (so A wins the first tie).
- CLEAR:
  - Each edge loads RFWE=1, RFWA=cnt, RFWD=0, then cnt+1.
  - On the edge with cnt=2^AWL-1, the next state is RUN.
  - AREADY and BREADY are held at 0 throughout.
- RUN grant, combinational from AVALID, BVALID and LAST:
  - Only one VALID high: grant that requester.
  - Both high: grant the requester that is not LAST.
  - AREADY = RUN & grantA; BREADY = RUN & grantB. At most one READY is high per cycle.
- Transfer occurs when VALID and READY are both high at an edge.
  - On a transfer from X: RFWA<=XWA, RFWD<=XWD, LAST<=X.
  - RFWE<=1, except RFWE<=0 if ZERO_R0=1 and XWA=0. The handshake still completes and LAST still updates.
- No transfer: RFWE<=0; RFWA and RFWD hold their values.
- Requester rules: once VALID is raised, hold VALID, address and data stable until READY. Dropping VALID before READY withdraws the request and is legal, with no side effects.
- BUSY = (state != RUN), decoded from registered state.

## Timing
- Write latency: a transfer at edge n gives RFWE high during cycle n to n+1. The RF commits the write at edge n+1.
- Sustained throughput: one write per cycle. With both requesters continuously valid, grants alternate A,B,A,B…
- Sweep, for release at edge 0 (first edge with RST=0):
  - After edge 0: state=CLEAR, RFWE=0.
  - Edges 1..2^AWL present RFWA=0..2^AWL-1 with RFWE=1.
  - State is RUN after edge 2^AWL, so BUSY drops and READY may assert in that same cycle.
  - The final sweep write and the first requester write never collide: the first requester write presents one edge later.
- RST asserted mid-sweep or mid-run: at that edge RFWE<=0 and all reset values load. The sweep restarts from 0 after release.
- Pending request when RST rises: not accepted and not written.

## Test plan
- Reset sweep (AWL=5, CLEAR_ON_RESET=1): RST high for 3 cycles, then low → exactly 32 RFWE pulses, RFWA=0..31 in order, RFWD=0; BUSY falls after the 33rd post-release edge; AREADY and BREADY stay 0 throughout.
- Single requester: AVALID=1, AWA=5, AWD=0xDEADBEEF in RUN → AREADY=1 the same cycle; the next cycle shows RFWE=1, RFWA=5, RFWD=0xDEADBEEF, and RF reg 5 reads 0xDEADBEEF afterwards.
- Contention: A and B both valid for 4 consecutive cycles, starting from reset LAST → grant order A,B,A,B; RFWA sequence matches the alternating addresses; never two READYs in one cycle.
- R0 suppression (ZERO_R0=1): B writes addr 0 data 0x1234 → BREADY=1, next-cycle RFWE=0, reg 0 stays 0. A following A-write still wins the tie, because LAST=B.
- Reset mid-sweep: assert RST after 10 sweep writes → RFWE=0 at the next edge; after release the sweep restarts at RFWA=0 and issues a full 32 writes.
- Stall and hold: B valid while A holds the grant (LAST=B, both valid) → B waits with stable data, is granted the next cycle, and its data is written unchanged. Withdrawing BVALID before grant → no B write occurs.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register-file write-port sequencer: zeroing sweep after reset, then round-robin A/B arbitration
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   AVALID/AREADY       requester A handshake (core writeback), AWA/AWD address/data
//   BVALID/BREADY       requester B handshake (host/debug loader), BWA/BWD address/data
//   RFWE/RFWA/RFWD      registered write enable/address/data into the register file
//   BUSY                high while the block is not in RUN
module rf_write_arbiter #(
    parameter int AWL            = 5,
    parameter int DWL            = 32,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter bit ZERO_R0        = 1'b1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           AVALID,
    output logic           AREADY,
    input  logic [AWL-1:0] AWA,
    input  logic [DWL-1:0] AWD,
    input  logic           BVALID,
    output logic           BREADY,
    input  logic [AWL-1:0] BWA,
    input  logic [DWL-1:0] BWD,
    output logic           RFWE,
    output logic [AWL-1:0] RFWA,
    output logic [DWL-1:0] RFWD,
    output logic           BUSY
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [AWL-1:0] CNT_MAX = '1;

    state_t         state;
    state_t         state_next;
    logic [AWL-1:0] cnt;
    logic           last_b;     // 1: B was granted last, so A wins the next tie
    logic           grant_a;
    logic           grant_b;
    logic           run_ok;
    logic           xfer_a;
    logic           xfer_b;
    logic [AWL-1:0] sel_wa;
    logic [DWL-1:0] sel_wd;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RESET: state_next = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            ST_CLEAR: if (cnt == CNT_MAX) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_RESET;
        endcase
    end

    // Round-robin grant: a lone requester always wins; on a tie the one
    // that was not served last wins.
    always_comb begin
        grant_a = AVALID & (~BVALID | last_b);
        grant_b = BVALID & (~AVALID | ~last_b);
    end

    // READY is also masked by RST so a request pending while reset is
    // asserted is never seen as accepted by the requester.
    assign run_ok = (state == ST_RUN) & ~RST;
    assign AREADY = run_ok & grant_a;
    assign BREADY = run_ok & grant_b;

    assign xfer_a = AVALID & AREADY;
    assign xfer_b = BVALID & BREADY;
    assign sel_wa = xfer_a ? AWA : BWA;
    assign sel_wd = xfer_a ? AWD : BWD;

    assign BUSY = (state != ST_RUN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            RFWE   <= 1'b0;
            RFWA   <= '0;
            RFWD   <= '0;
            cnt    <= '0;
            last_b <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    RFWE <= 1'b1;
                    RFWA <= cnt;
                    RFWD <= '0;
                    cnt  <= cnt + 1'b1;
                end
                ST_RUN: begin
                    if (xfer_a | xfer_b) begin
                        RFWA   <= sel_wa;
                        RFWD   <= sel_wd;
                        last_b <= xfer_b;
                        // Writes to r0 complete the handshake but never reach the RF.
                        RFWE   <= !(ZERO_R0 && (sel_wa == '0));
                    end else begin
                        RFWE <= 1'b0;
                    end
                end
                default: begin
                    RFWE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

    localparam int AWL = 5;
    localparam int DWL = 32;

    logic           CLK;
    logic           RST;
    logic           AVALID;
    logic           AREADY;
    logic [AWL-1:0] AWA;
    logic [DWL-1:0] AWD;
    logic           BVALID;
    logic           BREADY;
    logic [AWL-1:0] BWA;
    logic [DWL-1:0] BWD;
    logic           RFWE;
    logic [AWL-1:0] RFWA;
    logic [DWL-1:0] RFWD;
    logic           BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DWL-1:0] rf [2**AWL];

    rf_write_arbiter #(
        .AWL(AWL),
        .DWL(DWL),
        .CLEAR_ON_RESET(1'b1),
        .ZERO_R0(1'b1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .AVALID(AVALID),
        .AREADY(AREADY),
        .AWA(AWA),
        .AWD(AWD),
        .BVALID(BVALID),
        .BREADY(BREADY),
        .BWA(BWA),
        .BWD(BWD),
        .RFWE(RFWE),
        .RFWA(RFWA),
        .RFWD(RFWD),
        .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file the block writes into.
    always @(posedge CLK) begin
        if (RFWE === 1'b1) rf[RFWA] <= RFWD;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Walk n edges from the first edge after reset release, checking the sweep.
    task automatic sweep(input int n);
        int pulses;
        pulses = 0;
        for (int e = 0; e < n; e++) begin
            tick();
            if (RFWE === 1'b1) pulses++;
            if (e == 0) begin
                chk("sweep_first_rfwe", RFWE, 0);
            end else begin
                chk($sformatf("sweep_rfwe_%0d", e), RFWE, 1);
                chk($sformatf("sweep_rfwa_%0d", e), RFWA, e - 1);
                chk($sformatf("sweep_rfwd_%0d", e), RFWD, 0);
            end
            chk($sformatf("sweep_busy_%0d", e), BUSY, (e < 32) ? 1 : 0);
            chk($sformatf("sweep_aready_%0d", e), AREADY, (e == 32 && AVALID) ? 1 : 0);
            chk($sformatf("sweep_bready_%0d", e), BREADY, 0);
        end
        chk("sweep_pulses", pulses, n - 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AWL-1:0] a_addr;
        logic [AWL-1:0] b_addr;
        logic [DWL-1:0] a_data;
        logic [DWL-1:0] b_data;
        logic [AWL-1:0] exp_addr [4];
        logic [DWL-1:0] exp_data [4];
        logic           exp_a    [4];

        for (int i = 0; i < 2**AWL; i++) rf[i] = 32'hFFFF_FFFF;

        // Reset with both requesters pending: nothing may be accepted.
        RST = 1'b1;
        AVALID = 1'b1; AWA = 5'd7; AWD = 32'h0000_0077;
        BVALID = 1'b1; BWA = 5'd8; BWD = 32'h0000_0088;
        repeat (3) tick();
        chk("rst_rfwe", RFWE, 0);
        chk("rst_rfwa", RFWA, 0);
        chk("rst_rfwd", RFWD, 0);
        chk("rst_busy", BUSY, 1);
        chk("rst_aready", AREADY, 0);
        chk("rst_bready", BREADY, 0);

        // Full sweep; valids held high, A wins the first RUN cycle.
        RST = 1'b0;
        sweep(33);
        AVALID = 1'b0;
        BVALID = 1'b0;

        // Single requester A.
        AVALID = 1'b1; AWA = 5'd5; AWD = 32'hDEAD_BEEF;
        #1;
        chk("single_aready", AREADY, 1);
        chk("single_bready", BREADY, 0);
        tick();
        chk("single_rfwe", RFWE, 1);
        chk("single_rfwa", RFWA, 5);
        chk("single_rfwd", RFWD, 32'hDEAD_BEEF);
        AVALID = 1'b0;
        tick();
        chk("single_idle_rfwe", RFWE, 0);
        chk("single_hold_rfwa", RFWA, 5);
        chk("rf_reg5", rf[5], 32'hDEAD_BEEF);
        chk("rf_reg31_swept", rf[31], 0);
        chk("rf_reg0_swept", rf[0], 0);

        // R0 suppression via B.
        BVALID = 1'b1; BWA = 5'd0; BWD = 32'h0000_1234;
        #1;
        chk("r0_bready", BREADY, 1);
        chk("r0_aready", AREADY, 0);
        tick();
        chk("r0_rfwe", RFWE, 0);
        chk("r0_rfwa", RFWA, 0);
        BVALID = 1'b0;
        tick();
        chk("r0_rf0", rf[0], 0);

        // Contention for 4 cycles starting with LAST=B.
        exp_a[0] = 1'b1; exp_addr[0] = 5'd10; exp_data[0] = 32'hA000_0010;
        exp_a[1] = 1'b0; exp_addr[1] = 5'd11; exp_data[1] = 32'hB000_0011;
        exp_a[2] = 1'b1; exp_addr[2] = 5'd12; exp_data[2] = 32'hA000_0012;
        exp_a[3] = 1'b0; exp_addr[3] = 5'd13; exp_data[3] = 32'hB000_0013;
        a_addr = 5'd10; a_data = 32'hA000_0010;
        b_addr = 5'd11; b_data = 32'hB000_0011;
        AVALID = 1'b1; BVALID = 1'b1;
        for (int c = 0; c < 4; c++) begin
            AWA = a_addr; AWD = a_data; BWA = b_addr; BWD = b_data;
            #1;
            chk($sformatf("cont_aready_%0d", c), AREADY, exp_a[c]);
            chk($sformatf("cont_bready_%0d", c), BREADY, !exp_a[c]);
            chk($sformatf("cont_one_ready_%0d", c), AREADY & BREADY, 0);
            tick();
            chk($sformatf("cont_rfwe_%0d", c), RFWE, 1);
            chk($sformatf("cont_rfwa_%0d", c), RFWA, exp_addr[c]);
            chk($sformatf("cont_rfwd_%0d", c), RFWD, exp_data[c]);
            if (exp_a[c]) begin
                a_addr = 5'd12; a_data = 32'hA000_0012;
            end else begin
                b_addr = 5'd13; b_data = 32'hB000_0013;
            end
        end
        AVALID = 1'b0; BVALID = 1'b0;

        // Stall and hold: LAST=B, A wins, B waits then is written unchanged.
        AVALID = 1'b1; AWA = 5'd20; AWD = 32'hAAAA_0020;
        BVALID = 1'b1; BWA = 5'd21; BWD = 32'hBBBB_0021;
        #1;
        chk("stall_aready", AREADY, 1);
        chk("stall_bwait", BREADY, 0);
        tick();
        chk("stall_rfwa_a", RFWA, 20);
        AVALID = 1'b0;
        #1;
        chk("stall_bready", BREADY, 1);
        tick();
        chk("stall_rfwe_b", RFWE, 1);
        chk("stall_rfwa_b", RFWA, 21);
        chk("stall_rfwd_b", RFWD, 32'hBBBB_0021);
        BVALID = 1'b0;

        // Withdraw: B loses the tie, then drops BVALID before being granted.
        AVALID = 1'b1; AWA = 5'd22; AWD = 32'hAAAA_0022;
        BVALID = 1'b1; BWA = 5'd23; BWD = 32'h0000_CAFE;
        #1;
        chk("wd_aready", AREADY, 1);
        chk("wd_bwait", BREADY, 0);
        tick();
        chk("wd_rfwa_a", RFWA, 22);
        AVALID = 1'b0; BVALID = 1'b0;
        #1;
        chk("wd_bready", BREADY, 0);
        tick();
        chk("wd_rfwe", RFWE, 0);
        chk("wd_rfwa_hold", RFWA, 22);
        tick();
        chk("wd_rf23", rf[23], 0);
        chk("wd_rf21", rf[21], 32'hBBBB_0021);
        chk("wd_rf13", rf[13], 32'hB000_0013);

        // Reset mid-sweep after 10 sweep writes, then a full restart.
        RST = 1'b1;
        tick();
        chk("rst2_busy", BUSY, 1);
        RST = 1'b0;
        sweep(11);
        chk("mid_last_rfwa", RFWA, 9);
        RST = 1'b1;
        tick();
        chk("mid_rst_rfwe", RFWE, 0);
        chk("mid_rst_rfwa", RFWA, 0);
        chk("mid_rst_busy", BUSY, 1);
        RST = 1'b0;
        sweep(33);
        tick();
        chk("resweep_rf5", rf[5], 0);
        chk("resweep_rf31", rf[31], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
